// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard device model: scan-code FIFO serialised as 11-bit device-to-host frames.
// Latency: a push into an idle, empty block shows the start bit two clocks later; each frame takes 22*CLK_DIV clocks plus GAP_CYCLES.
// Backpressure: none; pushes that do not fit are dropped and latch the sticky overflow flag.
// Optional feature: define PS2_KBD_TX_AUTOBREAK_EN so that wr_release pushes the 0xF0 break prefix plus the code.
module ps2_kbd_tx #(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       wr_release,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       full,
    output logic       overflow
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t        state, state_nxt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_add;
    logic          push_two, push_ok, push_drop, pop;
    logic          fifo_empty, fits_one, fits_two;
    logic [7:0]    head;

    logic [TW-1:0] tmr;
    logic [3:0]    bit_idx;
    logic [10:0]   frame;
    logic          div_done, gap_done;
    logic          ps2_clk_nxt, ps2_data_nxt, busy_nxt;

`ifdef PS2_KBD_TX_AUTOBREAK_EN
    assign push_two = wr_release;
`else
    logic unused_release;
    assign push_two       = 1'b0;
    assign unused_release = wr_release;
`endif

    // ---------------- byte FIFO ----------------
    assign fifo_empty = (count == '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign fits_one   = !full;
    // A same-cycle pop never makes room: free space is judged on the current count.
    assign fits_two   = (count <= CW'(FIFO_DEPTH - 2));
    assign push_ok    = wr_en && (push_two ? fits_two : fits_one);
    assign push_drop  = wr_en && !push_ok;
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    assign head       = mem[rd_ptr];
    assign count_add  = push_ok ? (push_two ? CW'(2) : CW'(1)) : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            if (push_two) begin
                mem[wr_ptr]            <= 8'hF0;
                mem[wr_ptr + AW'(1)]   <= wr_data;
            end else begin
                mem[wr_ptr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + (push_two ? AW'(2) : AW'(1));
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + count_add - CW'(pop);
            if (push_drop)
                overflow <= 1'b1;
        end
    end

    // ---------------- frame FSM ----------------
    assign div_done = (tmr == TW'(CLK_DIV - 1));
    assign gap_done = (tmr == TW'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (!fifo_empty) state_nxt = ST_HIGH;
            ST_HIGH: if (div_done)    state_nxt = ST_LOW;
            ST_LOW:  if (div_done)    state_nxt = (bit_idx < 4'd10) ? ST_HIGH : ST_GAP;
            ST_GAP:  if (gap_done)    state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Timer restarts on every state change; the frame shifts only on LOW->HIGH so data moves with ps2_clk rising.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            tmr     <= '0;
            bit_idx <= '0;
            frame   <= '1;
        end else begin
            if (state_nxt != state || state == ST_IDLE)
                tmr <= '0;
            else
                tmr <= tmr + TW'(1);

            if (pop) begin
                frame   <= {1'b1, ~^head, head, 1'b0};
                bit_idx <= '0;
            end else if (state == ST_LOW && state_nxt == ST_HIGH) begin
                frame   <= {1'b1, frame[10:1]};
                bit_idx <= bit_idx + 4'd1;
            end
        end
    end

    always_comb begin
        ps2_clk_nxt  = 1'b1;
        ps2_data_nxt = 1'b1;
        busy_nxt     = 1'b1;
        unique case (state)
            ST_IDLE: busy_nxt     = 1'b0;
            ST_HIGH: ps2_data_nxt = frame[0];
            ST_LOW: begin
                ps2_clk_nxt  = 1'b0;
                ps2_data_nxt = frame[0];
            end
            ST_GAP:  busy_nxt     = 1'b1;
            default: busy_nxt     = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
        end else begin
            ps2_clk  <= ps2_clk_nxt;
            ps2_data <= ps2_data_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

Synthesizable PS/2 keyboard device model: the transmitting end of the PS/2 link that the keyboard receiver path consumes. It accepts scan-code bytes from a local writer into a small FIFO and serialises each one as a standard 11-bit PS/2 device-to-host frame on `ps2_clk`/`ps2_data`. It is used on-chip to drive the receiver without a physical keyboard, including make/break sequences with the 0xF0 prefix.

## Interface
- `CLK_DIV`, 50: `clk` cycles per `ps2_clk` half-period (≥2).
- `GAP_CYCLES`, 200: idle cycles with both lines high between frames (≥1).
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  push request, sampled each rising edge.
- `wr_data`  in  8  scan code to push.
- `wr_release`  in  1  with `wr_en`: push as key release (see Configuration).
- `ps2_clk`  out  1  PS/2 clock line, registered.
- `ps2_data`  out  1  PS/2 data line, registered.
- `busy`  out  1  frame or inter-frame gap in progress.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `overflow`  out  1  sticky: a push was dropped; cleared only by reset.

## Operation
- Reset values: `ps2_clk`=1, `ps2_data`=1, `busy`=0, `full`=0, `overflow`=0; FIFO empty; FSM in IDLE. Reset mid-frame aborts the frame; lines return high asynchronously, FIFO contents discarded.
- FIFO: push when `wr_en`=1 and not full; a push while full is dropped and sets `overflow`, even if a pop occurs the same cycle. Simultaneous accepted push and pop leave count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, HIGH, LOW, GAP.
  - IDLE: lines high, `busy`=0. If FIFO non-empty: pop head, load 11-bit frame {stop=1, parity, data[7:0], start=0}, bit index 0, go HIGH.
  - HIGH (`CLK_DIV` cycles): `ps2_clk`=1, `ps2_data`=current bit; data changes only on entry to HIGH. Then LOW.
  - LOW (`CLK_DIV` cycles): `ps2_clk`=0, data held. Then: if bit index <10, index+1, go HIGH; else go GAP.
  - GAP (`GAP_CYCLES` cycles): both lines high, `busy`=1. Then IDLE.
- Bit order: start(0), data LSB first, parity, stop(1). Parity is odd: parity = ~^data.
- `busy`=1 in HIGH, LOW, GAP.

## Timing
- Push at rising edge T into an empty FIFO with FSM IDLE: pop and load on edge T+1; `ps2_data` low (start) from edge T+2.
- First `ps2_clk` falling edge `CLK_DIV` cycles after `ps2_data` falls; each bit is stable `CLK_DIV` cycles before and `CLK_DIV` cycles after its falling edge.
- Frame length 22·`CLK_DIV` cycles; next start bit no earlier than `GAP_CYCLES`+1 cycles after final `ps2_clk` rise.
- `full` and `overflow` update on the edge after the push/pop that changes them.

## Configuration
- `PS2_KBD_TX_AUTOBREAK_EN` defined: `wr_en` with `wr_release`=1 atomically pushes 0xF0 then `wr_data` (two entries, same cycle). Accepted only if ≥2 entries free after any same-cycle pop is ignored; otherwise both dropped and `overflow` set. `wr_release`=0 pushes one byte.
- Not defined: `wr_release` ignored; every accepted push writes exactly one byte.

## Test plan
- Push 0x1C once, `CLK_DIV`=4: `ps2_data` sampled at each `ps2_clk` fall = 0,0,0,1,1,1,0,0,0,0,1; receiver `ps2_keyboard` reports 0x1C; `busy` clears `GAP_CYCLES` cycles after last rise.
- Push 0xF0: parity bit sampled = 1; receiver reports 0xF0, no parity error.
- Push 10 bytes on 10 consecutive cycles, `FIFO_DEPTH`=8: bytes 1–9 transmitted in order, byte 10 never appears, `full`=1 after the 9th push, `overflow`=1 and stays 1.
- Macro defined: push 0x1C with `wr_release`=1: two frames, 0xF0 then 0x1C, separated by ≥`GAP_CYCLES` idle; macro undefined, same stimulus: only 0x1C.
- Assert `clrn`=0 during data bit 4 of a frame: `ps2_clk`=`ps2_data`=1 immediately; after release, `busy`=0, FIFO empty, no partial frame resumes.
- Push and pop in the same cycle with 3 entries queued: count stays 3; order preserved across pointer wrap over 20 bytes.
